// File: rtl/au_pkg.sv
// Shared types and helpers for the add/sub unit requester front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package au_pkg;

   localparam int AU_W = 32;

   // Packed so that {z,n,c,v} lands on bits [3:0] of the response flags.
   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } au_flags_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } au_issue_state_t;

   // Signed overflow from operand/result sign bits; a subtract overflows when
   // the operand signs differ and the result sign departs from A.
   function automatic logic au_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb, input logic sub);
      if (sub) begin
         return (a_msb != b_msb) && (s_msb != a_msb);
      end
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/au_rsp_fifo.sv
// In-order response FIFO, DEPTH entries of W bits, first-word-fall-through head.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full_o reports no space; head data holds the last popped entry while empty.
module au_rsp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         vld_o,
   output logic [W-1:0] dat_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  last_q;
   logic          do_push, do_pop;

   assign vld_o   = (cnt_q != '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i && vld_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
   assign dat_o   = vld_o ? mem_q[rd_ptr_q] : last_q;

   // Pointers, occupancy and the value shown while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         cnt_q <= cnt_d;
      end
   end

   // Storage array; never exposed while empty, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/au_op_issuer.sv
// Requester front end for the 32-bit add/sub unit: issue op, capture sum/carry, queue flagged response.
// Latency: 1 op per 3 cycles; response at the FIFO head in the third cycle after the accept cycle.
// Backpressure: req_ready only in IDLE with FIFO space; optional saturation under macro AU_SAT_EN.
module au_op_issuer
   import au_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_sub,
   input  logic             req_sat,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      au_a,
   output logic [31:0]      au_b,
   output logic             au_ctrl,
   output logic             au_enabled,
   input  logic [31:0]      au_s,
   input  logic             au_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag
);

   localparam int RSP_W = AU_W + 4 + TAG_W;

   au_issue_state_t   state_q, state_d;
   logic [AU_W-1:0]   a_q, b_q;
   logic              ctrl_q;
   logic [TAG_W-1:0]  tag_q;
   logic              carry_q;
   logic              accept, push, fifo_full, ovf;
   logic [AU_W-1:0]   result;
   au_flags_t         flags;
   logic [RSP_W-1:0]  rsp_dat;

`ifdef AU_SAT_EN
   logic              sat_q;
`else
   logic              sat_unused;
   assign sat_unused = req_sat;
`endif

   assign au_a    = a_q;
   assign au_b    = b_q;
   assign au_ctrl = ctrl_q;

   // Issue sequencer: accept in IDLE, enable the unit for one cycle, collect in WAIT.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      accept     = 1'b0;
      au_enabled = 1'b0;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            // rst_n gating keeps ready low for the whole reset, not just after it.
            req_ready = rst_n && !fifo_full;
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            au_enabled = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            push    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operands stay put from one accept to the next; carry is taken while the
   // unit still sees the operands that produced it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= 1'b0;
         tag_q   <= '0;
         carry_q <= 1'b0;
`ifdef AU_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            a_q    <= req_a;
            b_q    <= req_b;
            ctrl_q <= req_sub;
            tag_q  <= req_tag;
`ifdef AU_SAT_EN
            sat_q  <= req_sat;
`endif
         end
         if (state_q == ISSUE) carry_q <= au_cout;
      end
   end

   // Result and flags from the registered sum, valid during WAIT.
   always_comb begin
      ovf    = au_overflow(a_q[AU_W-1], b_q[AU_W-1], au_s[AU_W-1], ctrl_q);
      result = au_s;
`ifdef AU_SAT_EN
      if (sat_q && ovf) begin
         result = a_q[AU_W-1] ? {1'b1, {(AU_W-1){1'b0}}} : {1'b0, {(AU_W-1){1'b1}}};
      end
`endif
      flags.z = (result == '0);
      flags.n = result[AU_W-1];
      flags.c = carry_q;
      flags.v = ovf;
   end

   au_rsp_fifo #(
      .W     (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i ({result, flags, tag_q}),
      .pop_i      (rsp_ready),
      .full_o     (fifo_full),
      .vld_o      (rsp_valid),
      .dat_o      (rsp_dat)
   );

   assign {rsp_result, rsp_flags, rsp_tag} = rsp_dat;

endmodule

// File: tb/tb_au_op_issuer.sv
// Self-checking bench for au_op_issuer with a behavioural add/sub unit attached.
// Latency: n/a (testbench).
// Backpressure: drives rsp_ready directly to exercise full and drain cases.
module tb_au_op_issuer;

   localparam int TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic             req_valid, req_ready;
   logic [31:0]      req_a, req_b;
   logic             req_sub, req_sat;
   logic [TAG_W-1:0] req_tag;
   logic [31:0]      au_a, au_b;
   logic             au_ctrl, au_enabled;
   logic [31:0]      au_s = '0;
   logic             au_cout;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic [3:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0]      res;
      logic [3:0]       flg;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   au_op_issuer #(.TAG_W(TAG_W), .RSP_DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .req_sat    (req_sat),
      .req_tag    (req_tag),
      .au_a       (au_a),
      .au_b       (au_b),
      .au_ctrl    (au_ctrl),
      .au_enabled (au_enabled),
      .au_s       (au_s),
      .au_cout    (au_cout),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_tag    (rsp_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Add/sub unit: combinational carry, sum registered when enabled.
   logic [32:0] unit_sum;
   assign unit_sum = {1'b0, au_a} + {1'b0, (au_ctrl ? ~au_b : au_b)} + {32'd0, au_ctrl};
   assign au_cout  = unit_sum[32];
   always @(posedge clk) if (au_enabled) au_s <= unit_sum[31:0];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait (bounded) for acceptance, record the expected response.
   // Returns 1 time unit after the accept edge.
   task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic sat, input logic [TAG_W-1:0] tag,
                          input logic [31:0] res, input logic [3:0] flg);
      exp_t e;
      int   k;
      req_a = a; req_b = b; req_sub = sub; req_sat = sat; req_tag = tag;
      req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 50) begin
         tick();
         k++;
      end
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
      if (req_ready) begin
         e.res = res; e.flg = flg; e.tag = tag;
         exp_q.push_back(e);
      end
      tick();
      req_valid = 1'b0;
   endtask

   // Reference arithmetic using wide signed math for overflow.
   task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic sat, input logic [TAG_W-1:0] tag);
      logic [32:0] w;
      longint      sa, sb, r;
      logic [31:0] res;
      logic        c, v;
      w  = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      res = w[31:0];
      c  = w[32];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = sub ? sa - sb : sa + sb;
      v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef AU_SAT_EN
      if (sat && v) res = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      push_op(a, b, sub, sat, tag, res, {(res == 32'd0), res[31], c, v});
   endtask

   // Scoreboard: compare the head whenever it will be popped on the next edge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_result", {32'd0, rsp_result}, {32'd0, mon_e.res});
            chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, mon_e.flg});
            chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, mon_e.tag});
         end
      end
   end

   initial begin
      int k;
      rst_n = 1'b1;
      req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; req_sat = 1'b0;
      req_tag = '0; rsp_ready = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_au_en", {63'd0, au_enabled}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_au_ab", {au_a, au_b}, 64'd0);
      chk("rst_au_ctrl", {63'd0, au_ctrl}, 64'd0);
      chk("rst_rsp_dat", {24'd0, rsp_result, rsp_flags, rsp_tag}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

      // First op: latency and enable pulse width.
      rsp_ready = 1'b1;
      push_op(32'h5, 32'h7, 1'b0, 1'b0, 4'd3, 32'h0000_000C, 4'b0000);
      chk("issue_au_en", {63'd0, au_enabled}, 64'd1);
      chk("issue_operands", {au_a, au_b}, {32'h5, 32'h7});
      chk("issue_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("issue_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
      chk("wait_au_en", {63'd0, au_enabled}, 64'd0);
      chk("wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("wait_operands", {au_a, au_b}, {32'h5, 32'h7});
      tick();
      chk("lat_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("idle_au_en", {63'd0, au_enabled}, 64'd0);
      tick();
      chk("popped_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("empty_hold_tag", {60'd0, rsp_tag}, 64'd3);
      chk("empty_hold_result", {32'd0, rsp_result}, 64'hC);

      // Directed arithmetic corners ({Z,N,C,V}).
      push_op(32'h5, 32'h5, 1'b1, 1'b0, 4'd5, 32'h0000_0000, 4'b1010);
      push_op(32'h0, 32'h1, 1'b1, 1'b0, 4'd6, 32'hFFFF_FFFF, 4'b0100);
`ifdef AU_SAT_EN
      push_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 4'd7, 32'h7FFF_FFFF, 4'b0001);
      push_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'd8, 32'h8000_0000, 4'b0111);
`else
      push_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 4'd7, 32'h8000_0000, 4'b0101);
      push_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'd8, 32'h0000_0000, 4'b1011);
`endif
      push_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, 4'd9, 32'h7FFF_FFFF, 4'b0011);
      for (int i = 0; i < 6; i++) begin
         model_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  TAG_W'(i + 10));
      end
      repeat (4) tick();

      // Backpressure: two fill the FIFO, the third waits for space.
      rsp_ready = 1'b0;
      push_op(32'h10, 32'h1, 1'b0, 1'b0, 4'd1, 32'h11, 4'b0000);
      push_op(32'h20, 32'h2, 1'b1, 1'b0, 4'd2, 32'h1E, 4'b0010);
      req_a = 32'h30; req_b = 32'h3; req_sub = 1'b0; req_sat = 1'b0; req_tag = 4'd3;
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("full_req_ready", {63'd0, req_ready}, 64'd0);
      end
      chk("full_head_valid", {63'd0, rsp_valid}, 64'd1);
      chk("full_head_tag", {60'd0, rsp_tag}, 64'd1);
      rsp_ready = 1'b1;
      k = 0;
      while (!req_ready && k < 20) begin
         tick();
         k++;
      end
      chk("drain_req_ready", {63'd0, req_ready}, 64'd1);
      if (req_ready) begin
         mon_e.res = 32'h33; mon_e.flg = 4'b0000; mon_e.tag = 4'd3;
         exp_q.push_back(mon_e);
      end
      tick();
      req_valid = 1'b0;
      repeat (5) tick();

      // Reset during WAIT with one response already queued.
      rsp_ready = 1'b0;
      push_op(32'h1, 32'h1, 1'b0, 1'b0, 4'd9, 32'h2, 4'b0000);
      repeat (2) tick();
      chk("pre_rst_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      push_op(32'h2, 32'h2, 1'b0, 1'b0, 4'd10, 32'h4, 4'b0000);
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_au_en", {63'd0, au_enabled}, 64'd0);
      chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("midrst_au_a", {32'd0, au_a}, 64'd0);
      tick();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_stale", {63'd0, rsp_valid}, 64'd0);
      end
      chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
      push_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd12, 32'h0, 4'b1010);
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         tick();
         k++;
      end
      tick();
      chk("all_rsp_seen", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/au_op_issuer.md
Name: au_op_issuer

Overview:
Requester-side front end for the 32-bit carry-lookahead add/sub unit. Accepts operation requests over a valid/ready handshake and drives the unit's operand/control/enable inputs. Captures the unit's registered sum and combinational carry at the correct cycles, derives Z/N/C/V flags, and queues tagged responses in a small in-order FIFO with its own valid/ready handshake. Sits between the AU decode/dispatch logic and the add/sub datapath.

Parameters:
TAG_W, 4, width of request/response tag
RSP_DEPTH, 2, response FIFO depth (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted on the edge where req_valid && req_ready
req_a  input  32  operand A
req_b  input  32  operand B
req_sub  input  1  1 = A-B, 0 = A+B
req_sat  input  1  saturate on signed overflow (honoured only with AU_SAT_EN)
req_tag  input  TAG_W  opaque tag echoed on response
au_a  output  32  operand A to add/sub unit
au_b  output  32  operand B to add/sub unit
au_ctrl  output  1  add/sub select to unit (also its carry-in)
au_enabled  output  1  result-register enable to unit
au_s  input  32  registered sum from unit
au_cout  input  1  combinational carry-out from unit
rsp_valid  output  1  response present at FIFO head
rsp_ready  input  1  consumer pops on the edge where rsp_valid && rsp_ready
rsp_result  output  32  result
rsp_flags  output  4  {Z,N,C,V}
rsp_tag  output  TAG_W  echoed tag

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset, applied immediately on rst_n low: FSM=IDLE; FIFO empty; req_ready=0 while asserted; au_a=au_b=0; au_ctrl=0; au_enabled=0; rsp_valid=0; rsp_result/rsp_flags/rsp_tag=0.
- Reset mid-operation discards the in-flight op; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: req_ready = (fifo_count < RSP_DEPTH). On accept: register req_a/req_b/req_sub into au_a/au_b/au_ctrl; latch tag and sat; go to ISSUE.
- ISSUE: au_enabled=1 for exactly this one cycle. Sample au_cout into carry_q at the edge ending ISSUE, since cout is combinational from the current operands. Go to WAIT.
- WAIT: au_enabled=0; au_a/au_b/au_ctrl held stable. Sample au_s at the edge ending WAIT. Compute flags and push {result, flags, tag} into the FIFO on that same edge. Go to IDLE.
- au_a/au_b/au_ctrl are held from accept until the next accept; no glitching between ops.
- Throughput: 1 op per 3 cycles. Latency: accept edge -> rsp_valid high 3 cycles later.
- FIFO never overflows: accept is gated on space, at most 1 op is in flight, and pops only free space.
- Pop and push on the same edge are legal; the count is unchanged.
- Response order equals request order.
- Flags:
  - Z = (result == 0).
  - N = result[31].
  - C = carry_q. For subtract, C=1 means no borrow.
  - V, add: a[31]==b[31] && s[31]!=a[31].
  - V, sub: a[31]!=b[31] && s[31]!=a[31].
- rsp_* reflect the FIFO head whenever rsp_valid=1. When empty they hold their last value.

Optional Feature:
AU_SAT_EN
- Defined: when req_sat=1 and V=1, the result is clamped to 0x7FFFFFFF if a[31]==0, else 0x80000000. Z and N are recomputed from the clamped value. C is unchanged. V stays 1 to report the saturation.
- Undefined: req_sat is ignored and the raw au_s is returned. Port list is identical in both builds.

Decomposition:
- Package au_pkg holds:
  - AU_W=32 constant
  - au_flags_t packed struct {z,n,c,v}
  - au_issue_state_t enum {IDLE,ISSUE,WAIT}
  - function au_overflow(a_msb,b_msb,s_msb,sub)
- One sub-module, au_rsp_fifo: parameterised synchronous FIFO (width, depth, async active-low reset) holding {result, flags, tag}.

Test Plan:
- add 0x5+0x7, tag 3, rsp_ready=1 -> rsp_result=0x0000000C, flags=0000, tag=3, rsp_valid high 3 cycles after accept; au_enabled pulses exactly 1 cycle.
- sub 0x5-0x5 -> result 0x00000000, flags Z=1 N=0 C=1 V=0.
- sub 0x0-0x1 -> result 0xFFFFFFFF, Z=0 N=1 C=0 V=0.
- add 0x7FFFFFFF+0x1, req_sat=1 -> without AU_SAT_EN: 0x80000000, N=1 V=1; with AU_SAT_EN: 0x7FFFFFFF, N=0 V=1.
- rsp_ready=0, present 3 back-to-back requests (tags 1,2,3) -> 2 accepted, req_ready stays 0 with count=2; raise rsp_ready -> responses drain in order 1,2, then tag 3 accepted and returned.
- assert rst_n=0 during WAIT -> au_enabled/rsp_valid/req_ready go 0 immediately; after release, FIFO empty and no stale response appears.
